// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
//   Shares the single data-cache port between the load unit and the drain of
//   retired stores. In IDLE it grants either a load or the oldest retired
//   store. It then runs that transaction as a request phase followed by a wait
//   phase, and returns load data or a store-completion pulse. Only one cache
//   transaction is outstanding at a time. A saturating starvation counter
//   stops a stream of loads from blocking a waiting store indefinitely. A load
//   squashed by branch recovery has its response dropped.
//
// Ports
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   load_req_*             : load request in; load_req_accepted pulses on grant
//   load_squash            : kills the in-flight load's response
//   load_resp_valid/_data  : one-cycle load data return
//   store_req_*            : oldest retired store; store_req_accepted pulses on ack
//   cache_req_*            : request to the cache, held until cache_req_ready
//   cache_resp_valid/_data : completion of the accepted cache request
module dcache_port_arbiter #(
    parameter int unsigned STORE_STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_req_valid,
    input  logic [31:0] load_req_addr,
    input  logic [3:0]  load_req_byte_mask,
    output logic        load_req_accepted,
    input  logic        load_squash,
    output logic        load_resp_valid,
    output logic [31:0] load_resp_data,
    input  logic        store_req_valid,
    input  logic [31:0] store_req_addr,
    input  logic [31:0] store_req_data,
    input  logic [3:0]  store_req_byte_mask,
    output logic        store_req_accepted,
    output logic        cache_req_valid,
    output logic        cache_req_is_store,
    output logic [31:0] cache_req_addr,
    output logic [31:0] cache_req_data,
    output logic [3:0]  cache_req_byte_mask,
    input  logic        cache_req_ready,
    input  logic        cache_resp_valid,
    input  logic [31:0] cache_resp_data
);

    localparam logic [7:0] LIMIT = 8'(STORE_STARVE_LIMIT);

    typedef enum logic [2:0] {
        IDLE,
        LD_REQ,
        LD_WAIT,
        ST_REQ,
        ST_WAIT
    } state_t;

    state_t      state, state_next;
    logic [7:0]  starve_cnt, starve_next;
    logic        squashed, squashed_next;
    logic [31:0] lat_addr;
    logic [31:0] lat_data;
    logic [3:0]  lat_mask;
    logic        store_grant;
    logic        load_grant;

    // Arbitration: a waiting store wins when loads have starved it long
    // enough or when there is no load competing for the port.
    always_comb begin
        store_grant = (state == IDLE) && store_req_valid &&
                      ((starve_cnt == LIMIT) || !load_req_valid);
        load_grant  = (state == IDLE) && !store_grant &&
                      load_req_valid && !load_squash;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (store_grant)     state_next = ST_REQ;
                else if (load_grant) state_next = LD_REQ;
            end
            LD_REQ:  if (cache_req_ready)  state_next = LD_WAIT;
            LD_WAIT: if (cache_resp_valid) state_next = IDLE;
            ST_REQ:  if (cache_req_ready)  state_next = ST_WAIT;
            ST_WAIT: if (cache_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The squash flag lives only as long as the load transaction does.
    always_comb begin
        squashed_next = squashed;
        if (state_next == IDLE) begin
            squashed_next = 1'b0;
        end else if (((state == LD_REQ) || (state == LD_WAIT)) && load_squash) begin
            squashed_next = 1'b1;
        end
    end

    always_comb begin
        starve_next = starve_cnt;
        if (store_grant) begin
            starve_next = '0;
        end else if (load_grant && store_req_valid && (starve_cnt < LIMIT)) begin
            starve_next = starve_cnt + 8'd1;
        end
    end

    always_comb begin
        load_req_accepted   = load_grant;
        cache_req_valid     = (state == LD_REQ) || (state == ST_REQ);
        cache_req_is_store  = (state == ST_REQ);
        cache_req_addr      = cache_req_valid ? lat_addr : '0;
        cache_req_data      = cache_req_valid ? lat_data : '0;
        cache_req_byte_mask = cache_req_valid ? lat_mask : '0;
        load_resp_valid     = (state == LD_WAIT) && cache_resp_valid &&
                              !squashed && !load_squash;
        load_resp_data      = load_resp_valid ? cache_resp_data : '0;
        store_req_accepted  = (state == ST_WAIT) && cache_resp_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            squashed   <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_mask   <= '0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            squashed   <= squashed_next;
            if (store_grant) begin
                lat_addr <= store_req_addr;
                lat_data <= store_req_data;
                lat_mask <= store_req_byte_mask;
            end else if (load_grant) begin
                lat_addr <= load_req_addr;
                lat_data <= '0;
                lat_mask <= load_req_byte_mask;
            end
        end
    end

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb_dcache_port_arbiter
//   Scoreboard bench for dcache_port_arbiter. The driver plays both the
//   requesters and the cache. It predicts each output event from the
//   arbitration rules and from the transaction timing that it chooses
//   itself, and it queues each prediction with the cycle in which it must
//   appear. A separate monitor pops and compares whenever the DUT shows an
//   output event.
module tb_dcache_port_arbiter;

    localparam int unsigned LIMIT = 2;

    localparam int K_LD_ACC  = 1;
    localparam int K_CREQ    = 2;
    localparam int K_LD_RESP = 3;
    localparam int K_ST_ACC  = 4;

    logic        clock;
    logic        reset;
    logic        load_req_valid;
    logic [31:0] load_req_addr;
    logic [3:0]  load_req_byte_mask;
    logic        load_req_accepted;
    logic        load_squash;
    logic        load_resp_valid;
    logic [31:0] load_resp_data;
    logic        store_req_valid;
    logic [31:0] store_req_addr;
    logic [31:0] store_req_data;
    logic [3:0]  store_req_byte_mask;
    logic        store_req_accepted;
    logic        cache_req_valid;
    logic        cache_req_is_store;
    logic [31:0] cache_req_addr;
    logic [31:0] cache_req_data;
    logic [3:0]  cache_req_byte_mask;
    logic        cache_req_ready;
    logic        cache_resp_valid;
    logic [31:0] cache_resp_data;

    dcache_port_arbiter #(.STORE_STARVE_LIMIT(LIMIT)) dut (
        .clock               (clock),
        .reset               (reset),
        .load_req_valid      (load_req_valid),
        .load_req_addr       (load_req_addr),
        .load_req_byte_mask  (load_req_byte_mask),
        .load_req_accepted   (load_req_accepted),
        .load_squash         (load_squash),
        .load_resp_valid     (load_resp_valid),
        .load_resp_data      (load_resp_data),
        .store_req_valid     (store_req_valid),
        .store_req_addr      (store_req_addr),
        .store_req_data      (store_req_data),
        .store_req_byte_mask (store_req_byte_mask),
        .store_req_accepted  (store_req_accepted),
        .cache_req_valid     (cache_req_valid),
        .cache_req_is_store  (cache_req_is_store),
        .cache_req_addr      (cache_req_addr),
        .cache_req_data      (cache_req_data),
        .cache_req_byte_mask (cache_req_byte_mask),
        .cache_req_ready     (cache_req_ready),
        .cache_resp_valid    (cache_resp_valid),
        .cache_resp_data     (cache_resp_data)
    );

    typedef struct {
        int          kind;
        int          cyc;
        bit          is_store;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   starve = 0;
    int   idle_arb = 0;
    bit   mon_en = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: run still going at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic void push(int k, bit st, logic [31:0] a, logic [31:0] d, logic [3:0] m);
        exp_t e;
        e.kind = k; e.cyc = cyc; e.is_store = st; e.addr = a; e.data = d; e.mask = m;
        q.push_back(e);
    endfunction

    // Monitor: one output event per cycle at most, since the port carries a
    // single transaction at a time.
    always @(negedge clock) begin
        if (mon_en) begin
            int   n;
            int   act;
            exp_t e;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                checks++; failures++;
                $display("FAIL missing_event: kind %0d not seen by cycle %0d (now %0d)",
                         q[0].kind, q[0].cyc, cyc);
                void'(q.pop_front());
            end
            n = int'(load_req_accepted) + int'(cache_req_valid) +
                int'(load_resp_valid) + int'(store_req_accepted);
            act = load_req_accepted ? K_LD_ACC : cache_req_valid ? K_CREQ :
                  load_resp_valid ? K_LD_RESP : K_ST_ACC;
            if (n > 1) begin
                checks++; failures++;
                $display("FAIL overlap: %0d output events in cycle %0d, required at most 1", n, cyc);
            end else if (n == 1) begin
                checks++;
                if (q.size() == 0 || q[0].cyc != cyc) begin
                    failures++;
                    $display("FAIL unexpected_event: kind %0d in cycle %0d, none expected", act, cyc);
                end else begin
                    e = q.pop_front();
                    if (act != e.kind) begin
                        failures++;
                        $display("FAIL event_kind: cycle %0d got kind %0d, required %0d", cyc, act, e.kind);
                    end else if (act == K_CREQ &&
                                 (cache_req_is_store !== e.is_store || cache_req_addr !== e.addr ||
                                  cache_req_data !== e.data || cache_req_byte_mask !== e.mask)) begin
                        failures++;
                        $display("FAIL cache_req: cycle %0d got st=%0b a=%h d=%h m=%h, required st=%0b a=%h d=%h m=%h",
                                 cyc, cache_req_is_store, cache_req_addr, cache_req_data, cache_req_byte_mask,
                                 e.is_store, e.addr, e.data, e.mask);
                    end else if (act == K_LD_RESP && load_resp_data !== e.data) begin
                        failures++;
                        $display("FAIL load_resp_data: cycle %0d got %h, required %h", cyc, load_resp_data, e.data);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string name);
        logic [104:0] outs;
        outs = {load_req_accepted, load_resp_valid, load_resp_data, store_req_accepted,
                cache_req_valid, cache_req_is_store, cache_req_addr, cache_req_data,
                cache_req_byte_mask};
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL %s: outputs %h, required all zero", name, outs);
        end
    endtask

    task automatic scramble();
        load_req_valid      = 1'($urandom);
        load_req_addr       = $urandom;
        load_req_byte_mask  = 4'($urandom);
        store_req_valid     = 1'($urandom);
        store_req_addr      = $urandom;
        store_req_data      = $urandom;
        store_req_byte_mask = 4'($urandom);
        cache_req_ready     = 1'($urandom);
        cache_resp_valid    = 1'($urandom);
        cache_resp_data     = $urandom;
        load_squash         = 1'($urandom);
    endtask

    // One arbitration cycle plus, if something is granted, its whole cache
    // transaction. sqm: 0 no squash while busy, 1 random squash while busy,
    // 2 squash in the first wait cycle (wdly >= 1), 3 squash with the response.
    task automatic txn(input bit lv, input logic [31:0] la, input logic [3:0] lm,
                       input bit sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sm, input bit sq0, input int rdly, input int wdly,
                       input logic [31:0] rdata, input int sqm, output bit granted);
        bit sw, lw, sqd;
        logic [31:0] a, d;
        logic [3:0] m;
        scramble();
        load_req_valid = lv; load_req_addr = la; load_req_byte_mask = lm;
        store_req_valid = sv; store_req_addr = sa; store_req_data = sd;
        store_req_byte_mask = sm; load_squash = sq0;
        sw = sv && (starve == int'(LIMIT) || !lv);
        lw = !sw && lv && !sq0;
        granted = sw || lw;
        if (lw) begin
            push(K_LD_ACC, 0, '0, '0, '0);
            if (sv && starve < int'(LIMIT)) starve++;
        end
        if (sw) starve = 0;
        step();
        if (granted) begin
            a = sw ? sa : la;
            d = sw ? sd : '0;
            m = sw ? sm : lm;
            sqd = 0;
            for (int i = 0; i <= rdly; i++) begin
                scramble();
                cache_req_ready = (i == rdly);
                load_squash = (sqm == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
                if (lw && load_squash) sqd = 1;
                push(K_CREQ, sw, a, d, m);
                step();
            end
            for (int i = 0; i <= wdly; i++) begin
                scramble();
                cache_resp_valid = (i == wdly);
                if (i == wdly) cache_resp_data = rdata;
                case (sqm)
                    1:       load_squash = ($urandom_range(0, 3) == 0);
                    2:       load_squash = (i == 0);
                    3:       load_squash = (i == wdly);
                    default: load_squash = 1'b0;
                endcase
                if (i == wdly) begin
                    if (sw) push(K_ST_ACC, 1, '0, '0, '0);
                    else if (!(sqd || load_squash)) push(K_LD_RESP, 0, '0, rdata, '0);
                end
                if (lw && load_squash) sqd = 1;
                step();
            end
        end
    endtask

    task automatic quiet();
        load_req_valid = 0; load_req_addr = '0; load_req_byte_mask = '0;
        store_req_valid = 0; store_req_addr = '0; store_req_data = '0;
        store_req_byte_mask = '0; load_squash = 0;
        cache_req_ready = 0; cache_resp_valid = 0; cache_resp_data = '0;
    endtask

    initial begin
        bit g;
        reset = 1;
        quiet();
        step();
        step();
        reset = 0;
        mon_en = 1;
        chk_zero("reset_outputs");

        // Load only: accepted cycle 0, request cycle 1, data cycle 2.
        txn(1, 32'h100, 4'hF, 0, '0, '0, '0, 0, 0, 0, 32'hDEADBEEF, 0, g);
        // Store only, cache not ready for 3 cycles.
        txn(0, '0, '0, 1, 32'h200, 32'h12345678, 4'h3, 0, 3, 1, 32'h0, 0, g);
        // Starvation with LIMIT=2: load, load, store, then loads resume.
        for (int i = 0; i < 4; i++)
            txn(1, 32'h300 + 32'(i), 4'hF, 1, 32'h400, 32'hA5A5A5A5, 4'hC, 0, 0, 0, 32'h1000 + 32'(i), 0, g);
        // Squash in LD_WAIT, then squash together with the response, then normal.
        txn(1, 32'h500, 4'h1, 0, '0, '0, '0, 0, 1, 2, 32'h11111111, 2, g);
        txn(1, 32'h504, 4'h2, 0, '0, '0, '0, 0, 0, 0, 32'h22222222, 3, g);
        txn(1, 32'h508, 4'h4, 0, '0, '0, '0, 0, 0, 1, 32'h33333333, 0, g);
        // Simultaneous arrival: load first, store in the next IDLE cycle.
        txn(1, 32'h600, 4'hF, 1, 32'h700, 32'hCAFEF00D, 4'hF, 0, 0, 0, 32'h44444444, 0, g);
        txn(0, '0, '0, 1, 32'h700, 32'hCAFEF00D, 4'hF, 0, 0, 0, 32'h0, 0, g);
        // Squash in IDLE blocks the load and nothing is granted.
        txn(1, 32'h800, 4'hF, 0, '0, '0, '0, 1, 0, 0, 32'h0, 0, g);
        idle_arb += int'(!g);

        // Reset while in ST_WAIT, then a late response.
        quiet();
        store_req_valid = 1; store_req_addr = 32'h900; store_req_data = 32'h55AA55AA;
        store_req_byte_mask = 4'hF;
        starve = 0;
        step();
        quiet();
        cache_req_ready = 1;
        push(K_CREQ, 1, 32'h900, 32'h55AA55AA, 4'hF);
        step();
        quiet();
        reset = 1;
        step();
        reset = 0;
        cache_resp_valid = 1;
        cache_resp_data = 32'hBAD0BAD0;
        chk_zero("reset_mid_op");
        step();
        quiet();
        chk_zero("after_late_resp");

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            int sqm;
            int wd;
            sqm = int'($urandom_range(0, 3));
            wd = int'($urandom_range(0, 3));
            if (sqm == 2 && wd == 0) wd = 1;
            txn(1'($urandom), $urandom, 4'($urandom), 1'($urandom), $urandom, $urandom,
                4'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), wd,
                $urandom, sqm, g);
            idle_arb += int'(!g);
        end

        quiet();
        repeat (3) step();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected events left, required 0", q.size());
        end
        $display("info: arbitration cycles without a grant=%0d", idle_arb);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_port_arbiter.md
# dcache_port_arbiter

Controller that shares the single data-cache port between the load unit and the store queue's retired-store drain. It arbitrates between a pending load and the oldest retired store, sequences one outstanding cache transaction at a time through a request/response state machine, and returns load data or a store-completion pulse. A starvation counter bounds how long loads can block stores. Loads squashed by branch recovery have their responses dropped.

## Interface
Parameters:
- STORE_STARVE_LIMIT, 8: consecutive cycles a waiting store may lose arbitration before it gets priority. Legal range 1..255.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_req_valid  in  1  load unit has a load for the cache.
- load_req_addr  in  ADDR (32)  load address.
- load_req_byte_mask  in  BYTE_MASK (4)  bytes requested.
- load_req_accepted  out  1  one-cycle pulse: load granted and latched.
- load_squash  in  1  branch recovery; kills the in-flight load, if any.
- load_resp_valid  out  1  one-cycle pulse: load data valid.
- load_resp_data  out  DATA (32)  load data returned by the cache.
- store_req_valid  in  1  store queue has a retired store to drain.
- store_req_addr  in  ADDR (32)  store address.
- store_req_data  in  DATA (32)  store data.
- store_req_byte_mask  in  BYTE_MASK (4)  bytes written.
- store_req_accepted  out  1  one-cycle pulse: store written to the cache; the store queue advances its head.
- cache_req_valid  out  1  request presented to the cache.
- cache_req_is_store  out  1  1 = write, 0 = read.
- cache_req_addr  out  ADDR (32)  request address.
- cache_req_data  out  DATA (32)  write data; 0 for loads.
- cache_req_byte_mask  out  BYTE_MASK (4)  request byte mask.
- cache_req_ready  in  1  cache accepts the presented request this cycle.
- cache_resp_valid  in  1  cache completes the accepted request (load data or store ack).
- cache_resp_data  in  DATA (32)  read data; don't-care for stores.

## Operation
- State machine: IDLE, LD_REQ, LD_WAIT, ST_REQ, ST_WAIT.
- IDLE: arbitrate combinationally.
  - Store wins if store_req_valid and (starve_cnt == STORE_STARVE_LIMIT or !load_req_valid).
  - Otherwise the load wins if load_req_valid and !load_squash.
- Load grant: pulse load_req_accepted the same cycle; latch addr and mask; go to LD_REQ.
- Store grant: latch addr, data and mask; go to ST_REQ. There is no pulse at grant.
- LD_REQ / ST_REQ: drive cache_req_* from the latched registers with cache_req_valid=1.
  - On cache_req_ready, go to LD_WAIT / ST_WAIT.
  - The request is never withdrawn once presented.
- LD_WAIT: on cache_resp_valid, go to IDLE. Pulse load_resp_valid with load_resp_data=cache_resp_data unless the squashed flag is set or load_squash is asserted that cycle.
- ST_WAIT: on cache_resp_valid, pulse store_req_accepted and go to IDLE. The store-queue entry stays untouched until this pulse, so forwarding from it remains valid.
- Squashed flag:
  - Set by load_squash in LD_REQ or LD_WAIT.
  - Cleared on entering IDLE.
  - load_squash has no effect in IDLE or in the store states.
- starve_cnt, width 8:
  - In IDLE with store_req_valid and the load granted: increment, saturating at STORE_STARVE_LIMIT.
  - Reset to 0 when a store is granted.
  - Hold otherwise, including while the arbiter is busy.
- cache_resp_valid is ignored in IDLE, LD_REQ and ST_REQ.

## Timing
- Reset: state=IDLE, starve_cnt=0, squashed=0, latched registers 0. All outputs are 0 the cycle after reset is sampled.
- Reset mid-transaction abandons it. No response pulse is issued, and a late cache_resp_valid is ignored in IDLE.
- load_req_accepted is combinational in IDLE.
- cache_req_valid rises the cycle after the grant.
- load_resp_valid and store_req_accepted are registered-state-driven and asserted in the cycle cache_resp_valid is seen in the WAIT state.
- Minimum occupancy per transaction, with ready=1 and the response one cycle later: IDLE 1 + REQ 1 + WAIT 1 = 3 cycles.
- Back-to-back: the next grant happens in the IDLE cycle after the response.
- Every output pulse lasts exactly one cycle.
- At most one cache transaction is outstanding.

## Test plan
- Load only: addr 0x100, mask 4'hF. The cache is ready immediately and responds 0xDEADBEEF one cycle later. Required: load_req_accepted in cycle 0; cache_req_valid in cycle 1 with is_store=0; load_resp_valid in cycle 2 with data 0xDEADBEEF.
- Store only: addr 0x200, data 0x12345678, mask 4'h3. cache_req_ready is held low for 3 cycles. Required: cache_req fields stable throughout; store_req_accepted is a single pulse on the ack; no load outputs.
- Starvation: load_req_valid and store_req_valid both held high, LIMIT=2. Required: exactly 2 loads granted, then the store granted, then starve_cnt returns to 0 and loads resume.
- Squash: load_squash asserted in LD_WAIT, and again separately in the same cycle as cache_resp_valid. Required in both cases: no load_resp_valid, arbiter back in IDLE, next load serviced normally.
- Reset mid-op: reset asserted in ST_WAIT, then cache_resp_valid arrives. Required: no store_req_accepted, all outputs 0, IDLE.
- Simultaneous arrival: load and store both valid with starve_cnt < LIMIT. Required: load granted first, starve_cnt=1, store granted in the next IDLE cycle.
